// File: rtl/shift_left_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_left_seq_pkg
//
// Types and helpers shared by the sequential shifters.
//   state_t       : handshake FSM states (IDLE / SHIFT / DONE)
//   clamp_amount  : clamps a requested shift distance to the operand width.
//                   Shifting a WIDTH-bit operand by WIDTH or more positions
//                   always gives zero, so there is no point spending extra
//                   cycles beyond WIDTH.
//   mux2          : bit-level 2:1 multiplexer cell used to build shift stages.
// ---------------------------------------------------------------------------
package shift_left_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Effective number of single-bit steps for a requested amount.
  function automatic int unsigned clamp_amount(input int unsigned amt,
                                               input int unsigned width);
    return (amt >= width) ? width : amt;
  endfunction

  // 2:1 mux cell: sel=0 passes d0, sel=1 passes d1.
  function automatic logic mux2(input logic sel, input logic d0, input logic d1);
    return sel ? d1 : d0;
  endfunction

endpackage

// File: rtl/shift_left_seq_step.sv
// ---------------------------------------------------------------------------
// shift_left_seq_step
//
// One-position logical left shift stage with enable, built from 2:1 mux
// cells. Purely combinational; the register lives in the parent.
//   d   in   WIDTH  current value
//   en  in   1      1: output d << 1 (zero into LSB), 0: output d unchanged
//   q   out  WIDTH  stage output
// ---------------------------------------------------------------------------
module shift_left_step
  import shift_left_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    // NOTE: every bit of q is assigned on every pass, so no latch can be
    // inferred even though the assignments sit inside a loop.
    q[0] = mux2(en, d[0], 1'b0);
    for (int i = 1; i < WIDTH; i++) begin
      q[i] = mux2(en, d[i], d[i-1]);
    end
  end

endmodule

// File: rtl/shift_left_seq.sv
// ---------------------------------------------------------------------------
// shift_left_seq
//
// Sequential logical left shifter: accepts (a, b) over a valid/ready
// handshake, shifts one bit per clock and presents s = a << b (zero-filled)
// until the consumer takes it. Shift distances of WIDTH or more are clamped
// to WIDTH steps, which yields zero.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a and b are valid
//   in_ready   out  1      block can accept an operand (state IDLE)
//   a          in   WIDTH  operand
//   b          in   AMT_W  unsigned shift amount
//   out_valid  out  1      s holds a finished result (state DONE)
//   out_ready  in   1      consumer accepts s
//   s          out  WIDTH  result; forced to zero outside DONE
//   busy       out  1      shift in progress (state SHIFT)
// ---------------------------------------------------------------------------
module shift_left_seq
  import shift_left_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             busy
);

  // Counter must hold values 0..WIDTH.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   step_q;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   eff;
  logic               accept;

  assign accept = in_valid && in_ready;

  // Clamped step count for the operand currently offered on b.
  always_comb begin
    eff = CNT_W'(clamp_amount(32'(b), WIDTH));
  end

  // Single shift stage; it only shifts while the FSM is in SHIFT and
  // otherwise passes shreg through, so the register simply holds.
  shift_left_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .d  (shreg),
    .en (state == SHIFT),
    .q  (step_q)
  );

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers: shift register and remaining-step counter.
  // Both are reset so an aborted operation leaves nothing behind.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
    end else if (accept) begin
      shreg <= a;
      count <= eff;
    end else if (state == SHIFT) begin
      shreg <= step_q;
      count <= count - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = (eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // count==1 means this edge performs the final shift.
        if (count == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Handoff cycle only; a new operand is taken from IDLE next cycle.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SHIFT);
    out_valid = (state == DONE);
    s         = (state == DONE) ? shreg : '0;
  end

endmodule
